// File: rtl/id_as_flow.sv
`default_nettype none
// ============================================================================
// Module      : id_as_flow
// Description : ID->AS pipeline register with load-use bubbles, stall hold,
//               sticky flush across stalls and a saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_as_flow #(
    parameter int CPU_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      id_valid_i,
    input  logic [CPU_WIDTH-1:0]      id_pc_i,
    input  logic [CPU_WIDTH-1:0]      id_inst_i,
    input  logic [CPU_WIDTH-1:0]      imm_i,
    input  logic [CPU_WIDTH-1:0]      reg1_rd_data_i,
    input  logic [CPU_WIDTH-1:0]      reg2_rd_data_i,
    input  logic [CPU_WIDTH-1:0]      csr_rd_data_i,
    input  logic                      reg_wr_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] reg_wr_adder_i,
    input  logic                      csr_wr_en_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_wr_adder_i,
    input  logic [3:0]                alu_op_i,
    input  logic                      ex_alu_src_sel_i,
    input  logic                      mem_rd_i,

    input  logic                      flow_wait_fc_i,
    input  logic                      jump_flush_i,
    input  logic                      as_stall_i,

    output logic                      as_valid_o,
    output logic [CPU_WIDTH-1:0]      as_pc_o,
    output logic [CPU_WIDTH-1:0]      as_inst_o,
    output logic [CPU_WIDTH-1:0]      as_imm_o,
    output logic [CPU_WIDTH-1:0]      as_reg1_data_o,
    output logic [CPU_WIDTH-1:0]      as_reg2_data_o,
    output logic [CPU_WIDTH-1:0]      as_csr_data_o,
    output logic                      as_reg_wr_en_o,
    output logic [REG_ADDR_WIDTH-1:0] as_reg_wr_adder_o,
    output logic                      as_csr_wr_en_o,
    output logic [CSR_ADDR_WIDTH-1:0] as_csr_wr_adder_o,
    output logic [3:0]                as_alu_op_o,
    output logic                      as_alu_src_sel_o,
    output logic                      as_mem_rd_o,

    output logic                      id_hold_o,
    output logic [15:0]               bubble_cnt_o
);

    localparam logic [CPU_WIDTH-1:0] c_NOP_INST = CPU_WIDTH'('h13);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LU_BUB = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t r_state;
    logic   r_flush_pend;
    logic   w_pend_hit;
    logic   w_load_use;

    // A pending flush can only exist while parked in HOLD; it is consumed on exit.
    assign w_pend_hit = r_flush_pend && (r_state == ST_HOLD);
    assign w_load_use = flow_wait_fc_i && id_valid_i;

    assign id_hold_o = as_stall_i | (w_load_use & ~jump_flush_i & ~w_pend_hit);

    always_ff @(posedge clk) begin
        if (rst || (!as_stall_i && (jump_flush_i || w_pend_hit || w_load_use))) begin
            as_valid_o        <= 1'b0;
            as_pc_o           <= '0;
            as_inst_o         <= c_NOP_INST;
            as_imm_o          <= '0;
            as_reg1_data_o    <= '0;
            as_reg2_data_o    <= '0;
            as_csr_data_o     <= '0;
            as_reg_wr_en_o    <= 1'b0;
            as_reg_wr_adder_o <= '0;
            as_csr_wr_en_o    <= 1'b0;
            as_csr_wr_adder_o <= '0;
            as_alu_op_o       <= '0;
            as_alu_src_sel_o  <= 1'b0;
            as_mem_rd_o       <= 1'b0;
        end else if (!as_stall_i) begin
            as_valid_o        <= id_valid_i;
            as_pc_o           <= id_pc_i;
            as_inst_o         <= id_inst_i;
            as_imm_o          <= imm_i;
            as_reg1_data_o    <= reg1_rd_data_i;
            as_reg2_data_o    <= reg2_rd_data_i;
            as_csr_data_o     <= csr_rd_data_i;
            as_reg_wr_en_o    <= reg_wr_en_i;
            as_reg_wr_adder_o <= reg_wr_adder_i;
            as_csr_wr_en_o    <= csr_wr_en_i;
            as_csr_wr_adder_o <= csr_wr_adder_i;
            as_alu_op_o       <= alu_op_i;
            as_alu_src_sel_o  <= ex_alu_src_sel_i;
            as_mem_rd_o       <= mem_rd_i;
        end
    end

    // Control state: state, sticky flush flag and saturating bubble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_flush_pend <= 1'b0;
            bubble_cnt_o <= 16'd0;
        end else if (as_stall_i) begin
            r_state <= ST_HOLD;
            if (jump_flush_i) begin
                r_flush_pend <= 1'b1;
            end
        end else if (jump_flush_i || w_pend_hit) begin
            r_state      <= ST_RUN;
            r_flush_pend <= 1'b0;
        end else if (w_load_use) begin
            r_state <= ST_LU_BUB;
            if (bubble_cnt_o != 16'hFFFF) begin
                bubble_cnt_o <= bubble_cnt_o + 16'd1;
            end
        end else begin
            r_state <= ST_RUN;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_as_flow.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_as_flow
// Description : Randomized self-checking bench for id_as_flow against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_as_flow;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] csr;
        logic        rwe;
        logic [4:0]  rwa;
        logic        cwe;
        logic [11:0] cwa;
        logic [3:0]  op;
        logic        src;
        logic        mrd;
    } as_t;

    logic clk = 1'b0;
    logic rst;
    as_t  id;
    logic fw, jf, st;

    as_t         m_as;
    logic        m_pend;
    int          m_cnt;
    int          tests = 0;
    int          fails = 0;

    logic        as_valid, as_reg_wr_en, as_csr_wr_en, as_alu_src_sel, as_mem_rd;
    logic [31:0] as_pc, as_inst, as_imm, as_r1, as_r2, as_csr;
    logic [4:0]  as_rwa;
    logic [11:0] as_cwa;
    logic [3:0]  as_op;
    logic        id_hold;
    logic [15:0] bubble_cnt;

    always #5 clk = ~clk;

    id_as_flow dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id.valid), .id_pc_i(id.pc), .id_inst_i(id.inst), .imm_i(id.imm),
        .reg1_rd_data_i(id.r1), .reg2_rd_data_i(id.r2), .csr_rd_data_i(id.csr),
        .reg_wr_en_i(id.rwe), .reg_wr_adder_i(id.rwa),
        .csr_wr_en_i(id.cwe), .csr_wr_adder_i(id.cwa),
        .alu_op_i(id.op), .ex_alu_src_sel_i(id.src), .mem_rd_i(id.mrd),
        .flow_wait_fc_i(fw), .jump_flush_i(jf), .as_stall_i(st),
        .as_valid_o(as_valid), .as_pc_o(as_pc), .as_inst_o(as_inst), .as_imm_o(as_imm),
        .as_reg1_data_o(as_r1), .as_reg2_data_o(as_r2), .as_csr_data_o(as_csr),
        .as_reg_wr_en_o(as_reg_wr_en), .as_reg_wr_adder_o(as_rwa),
        .as_csr_wr_en_o(as_csr_wr_en), .as_csr_wr_adder_o(as_cwa),
        .as_alu_op_o(as_op), .as_alu_src_sel_o(as_alu_src_sel), .as_mem_rd_o(as_mem_rd),
        .id_hold_o(id_hold), .bubble_cnt_o(bubble_cnt)
    );

    function automatic as_t bubble();
        as_t b = '0;
        b.inst = 32'h0000_0013;
        return b;
    endfunction

    function automatic as_t dut_as();
        return '{as_valid, as_pc, as_inst, as_imm, as_r1, as_r2, as_csr, as_reg_wr_en,
                 as_rwa, as_csr_wr_en, as_cwa, as_op, as_alu_src_sel, as_mem_rd};
    endfunction

    function automatic as_t rand_id(input logic valid);
        as_t r;
        r.valid = valid;
        r.pc = $urandom; r.inst = $urandom; r.imm = $urandom;
        r.r1 = $urandom; r.r2 = $urandom; r.csr = $urandom;
        r.rwe = 1'($urandom); r.rwa = 5'($urandom);
        r.cwe = 1'($urandom); r.cwa = 12'($urandom);
        r.op = 4'($urandom); r.src = 1'($urandom); r.mrd = 1'($urandom);
        return r;
    endfunction

    function automatic logic exp_hold();
        return st | (fw & id.valid & ~jf & ~m_pend);
    endfunction

    // One clock: reference model follows the priority rules on the inputs
    // presented at the edge, then outputs are given 1ns to settle.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_as = bubble(); m_pend = 1'b0; m_cnt = 0;
        end else if (st) begin
            if (jf) m_pend = 1'b1;
        end else if (jf || m_pend) begin
            m_as = bubble(); m_pend = 1'b0;
        end else if (fw && id.valid) begin
            m_as = bubble();
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_as = id;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; fw = 1'b0; jf = 1'b0; st = 1'b0; id = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        id = rand_id(1'b1);
        step(); step();
        tests++;
        if (dut_as() !== bubble()) begin
            fails++; $display("FAIL reset_as: got %h expected %h", dut_as(), bubble());
        end
        tests++;
        if (bubble_cnt !== 16'd0) begin
            fails++; $display("FAIL reset_cnt: got %0d expected 0", bubble_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_normal();
        idle_inputs();
        id.valid = 1'b1; id.pc = 32'h80; id.inst = 32'h0050_0093; id.rwa = 5'd1; id.rwe = 1'b1;
        #1;
        tests++;
        if (id_hold !== 1'b0) begin
            fails++; $display("FAIL normal_hold: got %b expected 0", id_hold);
        end
        step();
        tests++;
        if (as_valid !== 1'b1 || as_pc !== 32'h80 || as_rwa !== 5'd1 || as_inst !== 32'h0050_0093) begin
            fails++; $display("FAIL normal_capture: got v=%b pc=%h rwa=%0d inst=%h expected v=1 pc=80 rwa=1 inst=00500093",
                              as_valid, as_pc, as_rwa, as_inst);
        end
    endtask

    task automatic test_load_use();
        as_t a;
        rst = 1'b1; step(); idle_inputs();
        a = rand_id(1'b1);
        id = a; fw = 1'b1;
        #1;
        tests++;
        if (id_hold !== 1'b1) begin
            fails++; $display("FAIL lu_hold: got %b expected 1", id_hold);
        end
        step();
        tests++;
        if (dut_as() !== bubble() || bubble_cnt !== 16'd1) begin
            fails++; $display("FAIL lu_bubble: got %h cnt=%0d expected %h cnt=1", dut_as(), bubble_cnt, bubble());
        end
        fw = 1'b0;
        step();
        tests++;
        if (dut_as() !== a || bubble_cnt !== 16'd1) begin
            fails++; $display("FAIL lu_resume: got %h cnt=%0d expected %h cnt=1", dut_as(), bubble_cnt, a);
        end
        // Invalid ID with wait asserted must not bubble or hold.
        id = rand_id(1'b0); fw = 1'b1;
        #1;
        tests++;
        if (id_hold !== 1'b0) begin
            fails++; $display("FAIL lu_invalid_hold: got %b expected 0", id_hold);
        end
        step();
        tests++;
        if (dut_as() !== id || bubble_cnt !== 16'd1) begin
            fails++; $display("FAIL lu_invalid_capture: got %h cnt=%0d expected %h cnt=1", dut_as(), bubble_cnt, id);
        end
        fw = 1'b0;
    endtask

    task automatic test_stall_flush();
        as_t a, b;
        idle_inputs();
        a = rand_id(1'b1);
        id = a; step();
        id = rand_id(1'b1); st = 1'b1; jf = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            jf = 1'b0;
            tests++;
            if (dut_as() !== a) begin
                fails++; $display("FAIL stall_hold_%0d: got %h expected %h", i, dut_as(), a);
            end
        end
        st = 1'b0;
        b = rand_id(1'b1);
        id = b; fw = 1'b1;
        #1;
        tests++;
        if (id_hold !== 1'b0) begin
            fails++; $display("FAIL pend_hold: got %b expected 0", id_hold);
        end
        step();
        fw = 1'b0;
        tests++;
        if (dut_as() !== bubble()) begin
            fails++; $display("FAIL pend_bubble: got %h expected %h", dut_as(), bubble());
        end
        step();
        tests++;
        if (dut_as() !== b) begin
            fails++; $display("FAIL pend_next: got %h expected %h", dut_as(), b);
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            st  = ($urandom_range(0, 3) == 0);
            jf  = ($urandom_range(0, 5) == 0);
            fw  = ($urandom_range(0, 2) == 0);
            id  = rand_id(($urandom_range(0, 4) != 0));
            #1;
            tests++;
            if (id_hold !== exp_hold()) begin
                fails++; $display("FAIL rand_hold[%0d]: got %b expected %b", i, id_hold, exp_hold());
            end
            step();
            tests++;
            if (dut_as() !== m_as || bubble_cnt !== 16'(m_cnt)) begin
                fails++; $display("FAIL rand_as[%0d]: got %h cnt=%0d expected %h cnt=%0d",
                                  i, dut_as(), bubble_cnt, m_as, m_cnt);
            end
        end
        idle_inputs();
    endtask

    task automatic test_saturation_and_reset();
        idle_inputs();
        rst = 1'b1; step(); rst = 1'b0;
        id = rand_id(1'b1); fw = 1'b1;
        for (int i = 0; i < 65534; i++) step();
        tests++;
        if (bubble_cnt !== 16'hFFFE) begin
            fails++; $display("FAIL sat_fffe: got %h expected fffe", bubble_cnt);
        end
        step();
        tests++;
        if (bubble_cnt !== 16'hFFFF) begin
            fails++; $display("FAIL sat_ffff: got %h expected ffff", bubble_cnt);
        end
        step(); step();
        tests++;
        if (bubble_cnt !== 16'hFFFF || dut_as() !== bubble()) begin
            fails++; $display("FAIL sat_hold: got cnt=%h as=%h expected ffff %h", bubble_cnt, dut_as(), bubble());
        end
        rst = 1'b1;
        step();
        tests++;
        if (as_valid !== 1'b0 || bubble_cnt !== 16'd0 || dut_as() !== bubble()) begin
            fails++; $display("FAIL rst_lubub: got v=%b cnt=%0d as=%h expected v=0 cnt=0", as_valid, bubble_cnt, dut_as());
        end
        rst = 1'b0; fw = 1'b0;
        id = rand_id(1'b1);
        step();
        tests++;
        if (dut_as() !== id || bubble_cnt !== 16'd0) begin
            fails++; $display("FAIL rst_resume: got %h cnt=%0d expected %h cnt=0", dut_as(), bubble_cnt, id);
        end
    endtask

    initial begin
        m_as = bubble(); m_pend = 1'b0; m_cnt = 0;
        idle_inputs();
        #2;
        test_reset();
        test_normal();
        test_load_use();
        test_stall_flush();
        test_random();
        test_saturation_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_as_flow.md
ID_AS_FLOW -- requirements
Module: id_as_flow

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have decode/forwarding inputs: id_valid_i 1; id_pc_i, id_inst_i, imm_i `CPU_WIDTH; reg1_rd_data_i, reg2_rd_data_i, csr_rd_data_i `CPU_WIDTH (already forwarded); reg_wr_en_i 1; reg_wr_adder_i `REG_ADDR_WIDTH; csr_wr_en_i 1; csr_wr_adder_i `CSR_ADDR_WIDTH; alu_op_i 4; ex_alu_src_sel_i 1; mem_rd_i 1.
REQ-003 SHALL have control inputs: flow_wait_fc_i 1 (load-use hazard from forwarding unit); jump_flush_i 1 (AS-stage redirect, kill ID instruction); as_stall_i 1 (AS/MEM busy, hold AS register).
REQ-004 SHALL have registered outputs as_valid_o, as_pc_o, as_inst_o, as_imm_o, as_reg1_data_o, as_reg2_data_o, as_csr_data_o, as_reg_wr_en_o, as_reg_wr_adder_o, as_csr_wr_en_o, as_csr_wr_adder_o, as_alu_op_o, as_alu_src_sel_o, as_mem_rd_o, widths equal to matching inputs.
REQ-005 SHALL have outputs id_hold_o 1 (combinational: freeze IF/ID) and bubble_cnt_o 16 (registered, saturating count of inserted bubbles).

Function
REQ-006 SHALL implement FSM states RUN, LU_BUB, HOLD plus sticky flag flush_pend.
REQ-007 "Bubble" SHALL mean: as_valid_o=0, as_inst_o=32'h0000_0013, all write/read enables 0, all other fields 0.
REQ-008 Per-edge priority SHALL be: rst > as_stall_i > jump_flush_i > flush_pend > (flow_wait_fc_i & id_valid_i) > normal capture.
REQ-009 as_stall_i=1: all AS outputs SHALL hold; state->HOLD; if jump_flush_i=1 same cycle, flush_pend SHALL set.
REQ-010 jump_flush_i=1 with as_stall_i=0: capture bubble, clear flush_pend, state->RUN.
REQ-011 flush_pend=1 with as_stall_i=0: capture bubble (held ID instruction is stale), clear flush_pend, state->RUN.
REQ-012 flow_wait_fc_i & id_valid_i (no higher event): capture bubble, state->LU_BUB, bubble_cnt_o +1.
REQ-013 Normal: capture all inputs (as_valid_o=id_valid_i), state->RUN.
REQ-014 LU_BUB SHALL exit to RUN on first cycle flow_wait_fc_i=0 with normal capture; remain while flow_wait_fc_i=1 (each cycle a further bubble, counter +1).
REQ-015 HOLD SHALL exit on first cycle as_stall_i=0, applying REQ-010..013 that cycle.
REQ-016 id_hold_o SHALL equal as_stall_i | (flow_wait_fc_i & id_valid_i & ~jump_flush_i & ~flush_pend).
REQ-017 bubble_cnt_o SHALL saturate at 16'hFFFF, never wrap; flush bubbles not counted.
REQ-018 Latency SHALL be one cycle ID->AS; no combinational path from data inputs to AS outputs.
REQ-019 Ignored-valid rule: when id_valid_i=0, flow_wait_fc_i SHALL have no effect.

Reset
REQ-020 rst=1 at edge SHALL force bubble on all AS outputs, state RUN, flush_pend=0, bubble_cnt_o=0, overriding every other input, including mid-LU_BUB or HOLD.
REQ-021 id_hold_o during rst SHALL follow REQ-016 (no special case).

Verification
REQ-022 Normal flow: id_valid_i=1, pc=0x80, inst=0x00500093, reg_wr_adder=1 -> next cycle as_valid_o=1, as_pc_o=0x80, as_reg_wr_adder_o=1, id_hold_o=0.
REQ-023 Load-use: flow_wait_fc_i=1 for 1 cycle with valid ID -> id_hold_o=1 that cycle, AS gets bubble (inst 0x13), bubble_cnt_o=1; next cycle same ID instruction captured.
REQ-024 Stall+flush: as_stall_i=1 and jump_flush_i=1 together, stall held 3 cycles -> AS outputs unchanged 3 cycles, flush_pend=1; release -> bubble captured, then next ID instruction captured normally.
REQ-025 Saturation: preload 65535 bubbles via continuous flow_wait_fc_i -> bubble_cnt_o stays 16'hFFFF on further bubbles.
REQ-026 Reset mid-LU_BUB: assert rst while flow_wait_fc_i=1 -> next cycle as_valid_o=0, bubble_cnt_o=0, state RUN; after rst release with flow_wait_fc_i=0 normal capture resumes.
